// File: rtl/rv32i_load_store_pkg.sv
`default_nettype none
// ============================================================================
// Module : rv32i_load_store_pkg
// Brief  : funct3 codes, LSU state encoding and request classification helpers
// Rev    : 1.0
// ============================================================================
package rv32i_load_store_pkg;

    localparam logic [2:0] c_funct3_b  = 3'b000;
    localparam logic [2:0] c_funct3_h  = 3'b001;
    localparam logic [2:0] c_funct3_w  = 3'b010;
    localparam logic [2:0] c_funct3_bu = 3'b100;
    localparam logic [2:0] c_funct3_hu = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } lsu_state_e;

    // Unsigned variants exist only for loads.
    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        logic ok;
        case (funct3)
            c_funct3_b, c_funct3_h, c_funct3_w: ok = 1'b1;
            c_funct3_bu, c_funct3_hu:           ok = !we;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        logic bad;
        case (funct3)
            c_funct3_h, c_funct3_hu: bad = offset[0];
            c_funct3_w:              bad = (offset != 2'b00);
            default:                 bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_load_store_lanes.sv
`default_nettype none
// ============================================================================
// Module : rv32i_load_store_lanes
// Brief  : load lane extract/extend and sub-word store merge into a read word
// Rev    : 1.0
// ============================================================================
module rv32i_load_store_lanes
    import rv32i_load_store_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rword,
    input  logic [15:0]     wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] merged
);

    logic [4:0]  w_bshift;
    logic [4:0]  w_hshift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_bshift = {offset, 3'b000};
    assign w_hshift = {offset[1], 4'b0000};

    always_comb begin
        w_byte    = 8'(rword >> w_bshift);
        w_half    = 16'(rword >> w_hshift);
        load_data = rword;
        merged    = rword;
        case (funct3)
            c_funct3_b: begin
                load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
                merged    = (rword & ~(XLEN'(8'hFF) << w_bshift))
                          | (XLEN'(wdata[7:0]) << w_bshift);
            end
            c_funct3_h: begin
                load_data = {{(XLEN-16){w_half[15]}}, w_half};
                merged    = (rword & ~(XLEN'(16'hFFFF) << w_hshift))
                          | (XLEN'(wdata) << w_hshift);
            end
            c_funct3_bu: load_data = {{(XLEN-8){1'b0}}, w_byte};
            c_funct3_hu: load_data = {{(XLEN-16){1'b0}}, w_half};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_load_store.sv
`default_nettype none
// ============================================================================
// Module : rv32i_load_store
// Brief  : RV32I load/store unit with read-modify-write for sub-word stores
// Rev    : 1.0
// ============================================================================
module rv32i_load_store
    import rv32i_load_store_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int PORT_LEN     = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [2:0]          funct3_i,
    input  logic [XLEN-1:0]     addr_i,
    input  logic [XLEN-1:0]     wdata_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [XLEN-1:0]     rdata_o,
    output logic                misaligned_o,
    output logic                fault_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [PORT_LEN-1:0] mem_data_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    input  logic [PORT_LEN-1:0] mem_data_i,
    input  logic                mem_illegal_i
);

    localparam logic [1:0] c_last_wait = 2'(READ_LATENCY - 1);

    lsu_state_e          r_state;
    lsu_state_e          w_next_state;
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [1:0]          r_offset;
    logic [15:0]         r_wdata;
    logic                r_unsupported;
    logic                r_misaligned;
    logic [1:0]          r_wait_cnt;
    logic [XLEN-1:0]     r_rdata;
    logic [XLEN-1:0]     r_mem_addr;
    logic [PORT_LEN-1:0] r_mem_data;

    logic                w_legal;
    logic                w_misaligned;
    logic                w_accept;
    logic                w_clean;
    logic                w_wait_last;
    logic [XLEN-1:0]     w_load_data;
    logic [XLEN-1:0]     w_merged;

    assign w_legal      = funct3_legal(we_i, funct3_i);
    assign w_misaligned = addr_misaligned(funct3_i, addr_i[1:0]);
    assign w_accept     = (r_state == ST_IDLE) && req_i;
    assign w_clean      = w_legal && !w_misaligned;
    assign w_wait_last  = (r_wait_cnt == c_last_wait);

    rv32i_load_store_lanes #(
        .XLEN (XLEN)
    ) u_lanes (
        .funct3    (r_funct3),
        .offset    (r_offset),
        .rword     (mem_data_i),
        .wdata     (r_wdata),
        .load_data (w_load_data),
        .merged    (w_merged)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_i) begin
                    if (!w_clean)
                        w_next_state = ST_DONE;
                    else if (we_i && (funct3_i == c_funct3_w))
                        w_next_state = ST_WR;
                    else
                        w_next_state = ST_RD;
                end
            end
            ST_RD:   w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (w_wait_last)
                    w_next_state = r_we ? ST_WR : ST_DONE;
            end
            ST_WR:   w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_we          <= 1'b0;
            r_funct3      <= 3'b000;
            r_offset      <= 2'b00;
            r_wdata       <= 16'h0000;
            r_unsupported <= 1'b0;
            r_misaligned  <= 1'b0;
            r_wait_cnt    <= 2'b00;
            r_rdata       <= '0;
            r_mem_addr    <= '0;
            r_mem_data    <= '0;
        end else begin
            if (w_accept) begin
                r_we          <= we_i;
                r_funct3      <= funct3_i;
                r_offset      <= addr_i[1:0];
                r_wdata       <= wdata_i[15:0];
                r_unsupported <= !w_legal;
                r_misaligned  <= w_legal && w_misaligned;
                // Port address only moves for requests that will really touch memory.
                if (w_clean)
                    r_mem_addr <= {addr_i[XLEN-1:2], 2'b00};
                if (w_clean && we_i && (funct3_i == c_funct3_w))
                    r_mem_data <= wdata_i;
            end

            if (r_state == ST_RD)
                r_wait_cnt <= 2'b00;
            else if (r_state == ST_WAIT)
                r_wait_cnt <= r_wait_cnt + 2'd1;

            if ((r_state == ST_WAIT) && w_wait_last) begin
                if (r_we)
                    r_mem_data <= w_merged;
                else
                    r_rdata <= w_load_data;
            end
        end
    end

    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = (r_state == ST_DONE);
    assign mem_read_o   = (r_state == ST_RD);
    assign mem_write_o  = (r_state == ST_WR);
    assign misaligned_o = done_o && r_misaligned;
    // The decoder flag is already registered and sticky, so sampling it in DONE covers this access.
    assign fault_o      = done_o && (r_unsupported || mem_illegal_i);
    assign rdata_o      = r_rdata;
    assign mem_addr_o   = r_mem_addr;
    assign mem_data_o   = r_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_load_store.sv
`default_nettype none
// ============================================================================
// Module : tb_rv32i_load_store
// Brief  : directed and random checks of rv32i_load_store against a word/byte model
// Rev    : 1.0
// ============================================================================
module tb_rv32i_load_store;

    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  funct3_i = 3'b000;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        busy_o, done_o, misaligned_o, fault_o, mem_read_o, mem_write_o;
    logic [31:0] rdata_o, mem_addr_o, mem_data_o;
    logic [31:0] mem_data_i;
    logic        mem_illegal_i;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv32i_load_store #(
        .XLEN(32), .PORT_LEN(32), .READ_LATENCY(RL)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req_i), .we_i(we_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
        .misaligned_o(misaligned_o), .fault_o(fault_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i), .mem_illegal_i(mem_illegal_i)
    );

    // Memory environment: 1 KB RAM at 0x00010000, everything else illegal.
    logic [31:0] ram  [256];
    logic [31:0] pipe [RL];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = 8'h0;
    logic [31:0] pre_val = 32'h0;

    function automatic bit in_ram(input logic [31:0] a);
        return (a >= 32'h0001_0000) && (a < 32'h0001_0400);
    endfunction

    always @(posedge clk) begin
        if (pre_en)
            ram[pre_idx] <= pre_val;
        else if (mem_write_o && in_ram(mem_addr_o))
            ram[mem_addr_o[9:2]] <= mem_data_o;
        pipe[0] <= mem_read_o ? (in_ram(mem_addr_o) ? ram[mem_addr_o[9:2]] : 32'h0) : $urandom;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        if (reset_i)
            mem_illegal_i <= 1'b0;
        else if ((mem_read_o || mem_write_o) && !in_ram(mem_addr_o))
            mem_illegal_i <= 1'b1;
    end
    assign mem_data_i = pipe[RL-1];

    // Reference model state
    logic [31:0] m_mem [256];
    logic [31:0] m_rdata = 32'h0;
    bit          m_illegal = 1'b0;

    function automatic void model_op(input logic w, input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] d, output int e_lat, output logic [31:0] e_rd,
                                     output logic e_mis, output logic e_flt, output int e_nr, output int e_nw);
        int size, off;
        logic [31:0] mask, word, v;
        bit legal;
        off   = int'(a[1:0]);
        legal = w ? (f <= 3'd2) : (f <= 3'd2 || f == 3'd4 || f == 3'd5);
        size  = 1 << f[1:0];
        mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
        e_rd = m_rdata; e_mis = 1'b0; e_flt = 1'b0; e_nr = 0; e_nw = 0; e_lat = 1;
        if (!legal) begin
            e_flt = 1'b1;
        end else if (off % size != 0) begin
            e_mis = 1'b1;
            e_flt = m_illegal;
        end else begin
            if (!in_ram(a)) m_illegal = 1'b1;
            e_flt = m_illegal;
            word  = in_ram(a) ? m_mem[a[9:2]] : 32'h0;
            if (!w) begin
                e_lat = 2 + RL; e_nr = 1;
                v = (word >> (8*off)) & mask;
                if (f[2] == 1'b0 && size < 4 && v[8*size-1]) v = v | ~mask;
                m_rdata = v; e_rd = v;
            end else if (size == 4) begin
                e_lat = 2; e_nw = 1;
                if (in_ram(a)) m_mem[a[9:2]] = d;
            end else begin
                e_lat = 3 + RL; e_nr = 1; e_nw = 1;
                if (in_ram(a)) m_mem[a[9:2]] = (word & ~(mask << (8*off))) | ((d & mask) << (8*off));
            end
        end
    endfunction

    task automatic preset(input int idx, input logic [31:0] v);
        @(negedge clk);
        pre_en = 1'b1; pre_idx = idx[7:0]; pre_val = v;
        @(negedge clk);
        pre_en = 1'b0;
        m_mem[idx] = v;
    endtask

    // Issue one request and follow it to done_o, scrambling inputs while busy.
    task automatic run_op(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic mis, output logic flt,
                          output int nr, output int nw, output logic [31:0] maddr);
        @(negedge clk);
        req_i = 1'b1; we_i = w; funct3_i = f; addr_i = a; wdata_i = d;
        @(negedge clk);
        lat = 1; nr = 0; nw = 0;
        while (!done_o && lat < 20) begin
            nr += int'(mem_read_o);
            nw += int'(mem_write_o);
            req_i = 1'($urandom); we_i = 1'($urandom); funct3_i = 3'($urandom);
            addr_i = $urandom; wdata_i = $urandom;
            @(negedge clk);
            lat++;
        end
        req_i = 1'b0;
        rd = rdata_o; mis = misaligned_o; flt = fault_o; maddr = mem_addr_o;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; req_i = 1'b1; addr_i = $urandom; funct3_i = 3'b010;
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy_o, done_o, misaligned_o, fault_o, mem_read_o, mem_write_o} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctrl got %b required 000000",
                {busy_o, done_o, misaligned_o, fault_o, mem_read_o, mem_write_o}); end
        n_cmp++; if (rdata_o !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h required 0", rdata_o); end
        n_cmp++; if (mem_addr_o !== 32'h0 || mem_data_o !== 32'h0) begin
            n_bad++; $display("FAIL reset_port got %h/%h required 0/0", mem_addr_o, mem_data_o); end
        reset_i = 1'b0; req_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL idle_busy got %b required 0", busy_o); end
    endtask

    task automatic test_lw();
        int lat, nr, nw, el, enr, enw; logic [31:0] rd, ma, erd; logic mis, flt, emis, eflt;
        preset(1, 32'hDEAD_BEEF);
        model_op(1'b0, 3'b010, 32'h0001_0004, 32'h0, el, erd, emis, eflt, enr, enw);
        run_op(1'b0, 3'b010, 32'h0001_0004, 32'h0, lat, rd, mis, flt, nr, nw, ma);
        n_cmp++; if (lat !== 2 + RL) begin n_bad++; $display("FAIL lw_latency got %0d required %0d", lat, 2 + RL); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_data got %h required deadbeef", rd); end
        n_cmp++; if (nr !== 1 || nw !== 0) begin n_bad++; $display("FAIL lw_strobes got r%0d w%0d required r1 w0", nr, nw); end
        n_cmp++; if (ma !== 32'h0001_0004 || flt !== 1'b0) begin
            n_bad++; $display("FAIL lw_addr_fault got %h/%b required 00010004/0", ma, flt); end
    endtask

    task automatic test_lb_lbu();
        int lat, nr, nw, el, enr, enw; logic [31:0] rd, ma, erd; logic mis, flt, emis, eflt;
        preset(0, 32'h80FF_1234);
        model_op(1'b0, 3'b000, 32'h0001_0003, 32'h0, el, erd, emis, eflt, enr, enw);
        run_op(1'b0, 3'b000, 32'h0001_0003, 32'h0, lat, rd, mis, flt, nr, nw, ma);
        n_cmp++; if (rd !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_sext got %h required ffffff80", rd); end
        model_op(1'b0, 3'b100, 32'h0001_0003, 32'h0, el, erd, emis, eflt, enr, enw);
        run_op(1'b0, 3'b100, 32'h0001_0003, 32'h0, lat, rd, mis, flt, nr, nw, ma);
        n_cmp++; if (rd !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_zext got %h required 00000080", rd); end
    endtask

    task automatic test_sh_merge();
        int lat, nr, nw, el, enr, enw; logic [31:0] rd, ma, erd; logic mis, flt, emis, eflt;
        preset(0, 32'h1122_3344);
        model_op(1'b1, 3'b001, 32'h0001_0002, 32'h5555_ABCD, el, erd, emis, eflt, enr, enw);
        run_op(1'b1, 3'b001, 32'h0001_0002, 32'h5555_ABCD, lat, rd, mis, flt, nr, nw, ma);
        n_cmp++; if (lat !== 3 + RL) begin n_bad++; $display("FAIL sh_latency got %0d required %0d", lat, 3 + RL); end
        n_cmp++; if (nr !== 1 || nw !== 1) begin n_bad++; $display("FAIL sh_strobes got r%0d w%0d required r1 w1", nr, nw); end
        n_cmp++; if (ram[0] !== 32'hABCD_3344) begin n_bad++; $display("FAIL sh_word got %h required abcd3344", ram[0]); end
    endtask

    task automatic test_faults();
        int lat, nr, nw, el, enr, enw; logic [31:0] rd, ma, erd; logic mis, flt, emis, eflt;
        model_op(1'b0, 3'b010, 32'h0001_0002, 32'h0, el, erd, emis, eflt, enr, enw);
        run_op(1'b0, 3'b010, 32'h0001_0002, 32'h0, lat, rd, mis, flt, nr, nw, ma);
        n_cmp++; if (lat !== 1 || mis !== 1'b1 || flt !== 1'b0 || nr + nw !== 0) begin
            n_bad++; $display("FAIL lw_misaligned got lat%0d mis%b flt%b strobes%0d required lat1 mis1 flt0 strobes0",
                lat, mis, flt, nr + nw); end
        model_op(1'b1, 3'b011, 32'h0001_0000, 32'h0, el, erd, emis, eflt, enr, enw);
        run_op(1'b1, 3'b011, 32'h0001_0000, 32'h0, lat, rd, mis, flt, nr, nw, ma);
        n_cmp++; if (lat !== 1 || mis !== 1'b0 || flt !== 1'b1 || nr + nw !== 0) begin
            n_bad++; $display("FAIL bad_funct3 got lat%0d mis%b flt%b strobes%0d required lat1 mis0 flt1 strobes0",
                lat, mis, flt, nr + nw); end
        // Unsupported code with a misaligned address reports only the funct3 fault.
        model_op(1'b1, 3'b101, 32'h0001_0001, 32'h0, el, erd, emis, eflt, enr, enw);
        run_op(1'b1, 3'b101, 32'h0001_0001, 32'h0, lat, rd, mis, flt, nr, nw, ma);
        n_cmp++; if (mis !== 1'b0 || flt !== 1'b1 || nr + nw !== 0) begin
            n_bad++; $display("FAIL fault_priority got mis%b flt%b strobes%0d required mis0 flt1 strobes0",
                mis, flt, nr + nw); end
    endtask

    task automatic test_random();
        int lat, nr, nw, el, enr, enw; logic [31:0] rd, ma, erd, a, d; logic w, mis, flt, emis, eflt;
        logic [2:0] f;
        for (int i = 0; i < 64; i++) preset(i, $urandom);
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom); f = 3'($urandom); a = 32'h0001_0000 + ($urandom % 256); d = $urandom;
            model_op(w, f, a, d, el, erd, emis, eflt, enr, enw);
            run_op(w, f, a, d, lat, rd, mis, flt, nr, nw, ma);
            n_cmp++; if (lat !== el || nr !== enr || nw !== enw) begin n_bad++;
                $display("FAIL rnd_timing op%0d we%b f%0d a%h got lat%0d r%0d w%0d required lat%0d r%0d w%0d",
                    i, w, f, a, lat, nr, nw, el, enr, enw); end
            n_cmp++; if (rd !== erd || mis !== emis || flt !== eflt) begin n_bad++;
                $display("FAIL rnd_result op%0d we%b f%0d a%h got %h m%b f%b required %h m%b f%b",
                    i, w, f, a, rd, mis, flt, erd, emis, eflt); end
            if (enr + enw > 0) begin
                n_cmp++; if (ma !== {a[31:2], 2'b00}) begin n_bad++;
                    $display("FAIL rnd_addr op%0d got %h required %h", i, ma, {a[31:2], 2'b00}); end
            end
            if (enw > 0) begin
                n_cmp++; if (ram[a[9:2]] !== m_mem[a[9:2]]) begin n_bad++;
                    $display("FAIL rnd_store op%0d got %h required %h", i, ram[a[9:2]], m_mem[a[9:2]]); end
            end
        end
    endtask

    task automatic test_illegal();
        int lat, nr, nw, el, enr, enw; logic [31:0] rd, ma, erd; logic mis, flt, emis, eflt;
        model_op(1'b1, 3'b010, 32'h0003_0000, 32'h1234_5678, el, erd, emis, eflt, enr, enw);
        run_op(1'b1, 3'b010, 32'h0003_0000, 32'h1234_5678, lat, rd, mis, flt, nr, nw, ma);
        n_cmp++; if (lat !== 2 || nw !== 1 || flt !== 1'b1) begin n_bad++;
            $display("FAIL sw_illegal got lat%0d w%0d flt%b required lat2 w1 flt1", lat, nw, flt); end
        model_op(1'b0, 3'b010, 32'h0001_0004, 32'h0, el, erd, emis, eflt, enr, enw);
        run_op(1'b0, 3'b010, 32'h0001_0004, 32'h0, lat, rd, mis, flt, nr, nw, ma);
        n_cmp++; if (flt !== 1'b1 || rd !== erd) begin n_bad++;
            $display("FAIL sticky_fault got flt%b %h required flt1 %h", flt, rd, erd); end
    endtask

    task automatic test_reset_mid();
        int lat, nr, nw, el, enr, enw; logic [31:0] rd, ma, erd; logic mis, flt, emis, eflt;
        preset(4, 32'hCAFE_F00D);
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b1; funct3_i = 3'b000; addr_i = 32'h0001_0011; wdata_i = 32'h0000_0077;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (busy_o !== 1'b1 || mem_write_o !== 1'b0) begin n_bad++;
            $display("FAIL mid_busy got busy%b wr%b required busy1 wr0", busy_o, mem_write_o); end
        reset_i = 1'b1;
        @(negedge clk);
        n_cmp++; if ({busy_o, done_o, mem_write_o, mem_read_o} !== 4'b0) begin n_bad++;
            $display("FAIL mid_reset got %b required 0000", {busy_o, done_o, mem_write_o, mem_read_o}); end
        reset_i = 1'b0; req_i = 1'b0;
        m_illegal = 1'b0; m_rdata = 32'h0;
        repeat (4) begin
            @(negedge clk);
            n_cmp++; if (done_o !== 1'b0 || mem_write_o !== 1'b0) begin n_bad++;
                $display("FAIL mid_ghost got done%b wr%b required 00", done_o, mem_write_o); end
        end
        n_cmp++; if (ram[4] !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL mid_word got %h required cafef00d", ram[4]); end
        model_op(1'b0, 3'b010, 32'h0001_0004, 32'h0, el, erd, emis, eflt, enr, enw);
        run_op(1'b0, 3'b010, 32'h0001_0004, 32'h0, lat, rd, mis, flt, nr, nw, ma);
        n_cmp++; if (flt !== 1'b0 || rd !== erd) begin n_bad++;
            $display("FAIL post_reset_lw got flt%b %h required flt0 %h", flt, rd, erd); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_merge();
        test_faults();
        test_random();
        test_illegal();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
